// File: rtl/dec_cfg_loader.sv
// dec_cfg_loader
// Configuration master for the semaphore controller `dec`. After reset it
// loads the four divisor-RAM words, writes the initial divisor register and
// enables the semaphore. Once running, it serves divisor-change requests over
// a req/ack handshake and periodically reads status register 3.
//
// Ports
//   clk          rising-edge clock
//   clrn         asynchronous active-low reset
//   start        boot request (AUTO_START=0) or reconfigure request from RUN
//   div_req      divisor-change request level, held until div_ack
//   div_val      requested divisor index
//   div_ack      one-cycle pulse, coincident with the reg-1 write
//   poll_en      enables periodic status polling
//   status       last value captured from reg 3
//   status_vld   one-cycle pulse when status updates
//   busy         high in every state except IDLE and RUN
//   done         high while in RUN
//   ctl_wr/ctl_rd/ctl_addr/ctl_wrdata/ctl_rddata   register port of `dec`
//   ram_wr/ram_addr/ram_wrdata                     divisor RAM port of `dec`
module dec_cfg_loader #(
    parameter logic [31:0] INIT_W0     = 32'h0A3C5032,
    parameter logic [31:0] INIT_W1     = 32'h0A1E0A64,
    parameter logic [31:0] INIT_W2     = 32'h0A1E281E,
    parameter logic [31:0] INIT_W3     = 32'h0A463214,
    parameter logic [1:0]  INIT_DIV    = 2'd0,
    parameter bit          AUTO_START  = 1'b1,
    parameter int unsigned POLL_PERIOD = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic        div_req,
    input  logic [1:0]  div_val,
    output logic        div_ack,
    input  logic        poll_en,
    output logic [31:0] status,
    output logic        status_vld,
    output logic        busy,
    output logic        done,
    output logic        ctl_wr,
    output logic        ctl_rd,
    output logic [1:0]  ctl_addr,
    output logic [31:0] ctl_wrdata,
    input  logic [31:0] ctl_rddata,
    output logic        ram_wr,
    output logic [1:0]  ram_addr,
    output logic [31:0] ram_wrdata
);

    localparam logic [15:0] POLL_LAST = 16'(POLL_PERIOD - 1);

    typedef enum logic [3:0] {
        IDLE,
        RAM_WR,
        DIV_WR,
        EN_WR,
        GAP,
        RUN,
        UPD_WR,
        POLL_RD,
        POLL_CAP
    } state_t;

    state_t      state, state_nx;
    state_t      ret, ret_nx;
    logic [1:0]  idx, idx_nx;
    logic [15:0] timer, timer_nx;
    logic        poll_pend, poll_pend_nx;
    logic        timer_hit;

    logic        div_ack_nx, status_vld_nx, busy_nx, done_nx;
    logic        ctl_wr_nx, ctl_rd_nx, ram_wr_nx;
    logic [1:0]  ctl_addr_nx, ram_addr_nx;
    logic [31:0] ctl_wrdata_nx, ram_wrdata_nx;

    function automatic logic [31:0] init_word(input logic [1:0] i);
        case (i)
            2'd0:    return INIT_W0;
            2'd1:    return INIT_W1;
            2'd2:    return INIT_W2;
            default: return INIT_W3;
        endcase
    endfunction

    // The timer reaching its last count in RUN counts as a pending poll in the
    // same cycle, so the read issues right after the last period cycle.
    assign timer_hit = (state == RUN) && poll_en && (timer == POLL_LAST);

    // Next-state logic. Every strobe state goes through GAP; `ret` remembers
    // where GAP should continue.
    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (AUTO_START || start) begin
                    state_nx = RAM_WR;
                    idx_nx   = 2'd0;
                end
            end
            RAM_WR: begin
                state_nx = GAP;
                ret_nx   = (idx == 2'd3) ? DIV_WR : RAM_WR;
                idx_nx   = idx + 2'd1;
            end
            DIV_WR: begin
                state_nx = GAP;
                ret_nx   = EN_WR;
            end
            EN_WR, UPD_WR: begin
                state_nx = GAP;
                ret_nx   = RUN;
            end
            GAP:      state_nx = ret;
            RUN: begin
                if (start) begin
                    state_nx = RAM_WR;
                    idx_nx   = 2'd0;
                end else if (div_req) begin
                    state_nx = UPD_WR;
                end else if (poll_pend || timer_hit) begin
                    state_nx = POLL_RD;
                end
            end
            POLL_RD:  state_nx = POLL_CAP;
            POLL_CAP: state_nx = RUN;
            default:  state_nx = IDLE;
        endcase
    end

    // Poll timer and pending flag. The timer only runs while staying in RUN
    // with polling enabled; the pending flag survives poll_en dropping so a
    // scheduled read always completes, but a reboot discards it.
    always_comb begin
        timer_nx     = 16'd0;
        poll_pend_nx = poll_pend;
        if ((state == RUN) && (state_nx == RUN) && poll_en && !timer_hit) begin
            timer_nx = timer + 16'd1;
        end
        if ((state_nx == POLL_RD) || ((state == RUN) && start)) begin
            poll_pend_nx = 1'b0;
        end else if (timer_hit) begin
            poll_pend_nx = 1'b1;
        end
    end

    // Outputs are decoded from the state being entered and then registered,
    // so each bus is valid for exactly the cycle its state is occupied.
    always_comb begin
        ram_wr_nx     = 1'b0;
        ram_addr_nx   = 2'd0;
        ram_wrdata_nx = 32'd0;
        ctl_wr_nx     = 1'b0;
        ctl_rd_nx     = 1'b0;
        ctl_addr_nx   = 2'd0;
        ctl_wrdata_nx = 32'd0;
        div_ack_nx    = 1'b0;
        status_vld_nx = 1'b0;
        busy_nx       = (state_nx != IDLE) && (state_nx != RUN);
        done_nx       = (state_nx == RUN);
        case (state_nx)
            RAM_WR: begin
                ram_wr_nx     = 1'b1;
                ram_addr_nx   = idx_nx;
                ram_wrdata_nx = init_word(idx_nx);
            end
            DIV_WR: begin
                ctl_wr_nx     = 1'b1;
                ctl_addr_nx   = 2'd1;
                ctl_wrdata_nx = {30'd0, INIT_DIV};
            end
            EN_WR: begin
                ctl_wr_nx     = 1'b1;
                ctl_addr_nx   = 2'd0;
                ctl_wrdata_nx = 32'd1;
            end
            UPD_WR: begin
                ctl_wr_nx     = 1'b1;
                ctl_addr_nx   = 2'd1;
                ctl_wrdata_nx = {30'd0, div_val};
                div_ack_nx    = 1'b1;
            end
            POLL_RD: begin
                ctl_rd_nx   = 1'b1;
                ctl_addr_nx = 2'd3;
            end
            POLL_CAP: status_vld_nx = 1'b1;
            default: ;
        endcase
    end

    // State, bookkeeping and registered outputs. Read data is valid on the
    // edge that ends the POLL_RD cycle, so it is captured there.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            ret        <= IDLE;
            idx        <= 2'd0;
            timer      <= 16'd0;
            poll_pend  <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= 2'd0;
            ram_wrdata <= 32'd0;
            ctl_wr     <= 1'b0;
            ctl_rd     <= 1'b0;
            ctl_addr   <= 2'd0;
            ctl_wrdata <= 32'd0;
            div_ack    <= 1'b0;
            status     <= 32'd0;
            status_vld <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            ret        <= ret_nx;
            idx        <= idx_nx;
            timer      <= timer_nx;
            poll_pend  <= poll_pend_nx;
            ram_wr     <= ram_wr_nx;
            ram_addr   <= ram_addr_nx;
            ram_wrdata <= ram_wrdata_nx;
            ctl_wr     <= ctl_wr_nx;
            ctl_rd     <= ctl_rd_nx;
            ctl_addr   <= ctl_addr_nx;
            ctl_wrdata <= ctl_wrdata_nx;
            div_ack    <= div_ack_nx;
            status_vld <= status_vld_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            if (state == POLL_RD) begin
                status <= ctl_rddata;
            end
        end
    end

endmodule

// File: tb/tb_dec_cfg_loader.sv
// tb_dec_cfg_loader
// Directed bench for dec_cfg_loader: boot sequence, divisor updates, status
// polling, write/poll collision, reset in mid-boot and manual start mode.
// Expected values are hand-derived cycle by cycle from the release edge.
module tb_dec_cfg_loader;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start, div_req, poll_en;
    logic [1:0]  div_val;
    logic [31:0] ctl_rddata;

    logic        div_ack, status_vld, busy, done;
    logic        ctl_wr, ctl_rd, ram_wr;
    logic [1:0]  ctl_addr, ram_addr;
    logic [31:0] status, ctl_wrdata, ram_wrdata;

    logic        start_m;
    logic        div_ack_m, status_vld_m, busy_m, done_m;
    logic        ctl_wr_m, ctl_rd_m, ram_wr_m;
    logic [1:0]  ctl_addr_m, ram_addr_m;
    logic [31:0] status_m, ctl_wrdata_m, ram_wrdata_m;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [4] = '{32'h0A3C5032, 32'h0A1E0A64, 32'h0A1E281E, 32'h0A463214};
    localparam logic [31:0] STUB_DATA = 32'hA5A5_0003;

    always #5 clk = ~clk;

    // Register stub: reg 3 returns a fixed pattern only while it is being read.
    assign ctl_rddata = (ctl_rd && (ctl_addr == 2'd3)) ? STUB_DATA : 32'd0;

    dec_cfg_loader #(.AUTO_START(1'b1), .POLL_PERIOD(16)) u_auto (
        .clk(clk), .clrn(clrn), .start(start), .div_req(div_req), .div_val(div_val),
        .div_ack(div_ack), .poll_en(poll_en), .status(status), .status_vld(status_vld),
        .busy(busy), .done(done), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_addr(ctl_addr),
        .ctl_wrdata(ctl_wrdata), .ctl_rddata(ctl_rddata), .ram_wr(ram_wr),
        .ram_addr(ram_addr), .ram_wrdata(ram_wrdata)
    );

    dec_cfg_loader #(.AUTO_START(1'b0), .POLL_PERIOD(16)) u_man (
        .clk(clk), .clrn(clrn), .start(start_m), .div_req(1'b0), .div_val(2'd0),
        .div_ack(div_ack_m), .poll_en(1'b0), .status(status_m), .status_vld(status_vld_m),
        .busy(busy_m), .done(done_m), .ctl_wr(ctl_wr_m), .ctl_rd(ctl_rd_m),
        .ctl_addr(ctl_addr_m), .ctl_wrdata(ctl_wrdata_m), .ctl_rddata(32'd0),
        .ram_wr(ram_wr_m), .ram_addr(ram_addr_m), .ram_wrdata(ram_wrdata_m)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [1:0] v, input logic p);
        start   = s;
        div_req = r;
        div_val = v;
        poll_en = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] vec(input logic rw, input logic [1:0] ra, input logic [31:0] rd,
                                         input logic cw, input logic cr, input logic [1:0] ca,
                                         input logic [31:0] cd, input logic ack, input logic sv,
                                         input logic bz, input logic dn);
        return {53'd0, rw, ra, rd, cw, cr, ca, cd, ack, sv, bz, dn};
    endfunction

    function automatic logic [127:0] obsA();
        return vec(ram_wr, ram_addr, ram_wrdata, ctl_wr, ctl_rd, ctl_addr, ctl_wrdata,
                   div_ack, status_vld, busy, done);
    endfunction

    function automatic logic [127:0] obsM();
        return vec(ram_wr_m, ram_addr_m, ram_wrdata_m, ctl_wr_m, ctl_rd_m, ctl_addr_m,
                   ctl_wrdata_m, div_ack_m, status_vld_m, busy_m, done_m);
    endfunction

    function automatic logic [127:0] vBusy();
        return vec(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [127:0] vDone();
        return vec(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic logic [127:0] vUpd(input logic [1:0] v);
        return vec(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd1, {30'd0, v}, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [127:0] vRd();
        return vec(1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 2'd3, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [127:0] vCap();
        return vec(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic logic [127:0] expBoot(input int c);
        logic [1:0] i;
        i = 2'((c - 1) / 2);
        if (c == 13) return vDone();
        if ((c % 2 == 1) && (c <= 7))
            return vec(1'b1, i, words[i], 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (c == 9)
            return vec(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (c == 11)
            return vec(1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd0, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        return vBusy();
    endfunction

    // Walks cycles 1..13 after a boot trigger. Optionally pokes start (cycle 3)
    // and a short div_req burst (cycles 2..4) into the busy window.
    task automatic checkBoot(input string tag, input bit pokeStart, input bit pokeReq);
        for (int c = 1; c <= 13; c++) begin
            tick();
            checkOutput($sformatf("%s_c%0d", tag, c), obsA(), expBoot(c));
            start = pokeStart && (c == 3);
            if (pokeReq) div_req = (c >= 2) && (c <= 4);
        end
    endtask

    // At most one strobe may be active in any cycle.
    always @(negedge clk) begin
        if (clrn === 1'b1)
            checkOutput("one_strobe", 128'($countones({ram_wr, ctl_wr, ctl_rd}) > 1), 128'd0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] vals [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        start_m = 1'b0;
        clrn    = 1'b0;
        repeat (3) tick();
        checkOutput("rst_out", obsA(), 128'd0);
        checkOutput("rst_status", 128'(status), 128'd0);
        checkOutput("rst_man", obsM(), 128'd0);

        $display("[TB] boot after release");
        clrn = 1'b1;
        checkBoot("boot", 1'b0, 1'b0);
        checkOutput("man_idle", obsM(), 128'd0);

        $display("[TB] divisor updates");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, vals[k], 1'b0);
            tick();
            checkOutput($sformatf("upd_wr%0d", k), obsA(), vUpd(vals[k]));
            applyStimulus(1'b0, 1'b0, vals[k], 1'b0);
            tick();
            checkOutput($sformatf("upd_gap%0d", k), obsA(), vBusy());
            tick();
            checkOutput($sformatf("upd_run%0d", k), obsA(), vDone());
        end

        $display("[TB] status polling");
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        repeat (15) tick();
        checkOutput("poll_early", obsA(), vDone());
        tick();
        checkOutput("poll_rd1", obsA(), vRd());
        tick();
        checkOutput("poll_cap1", obsA(), vCap());
        checkOutput("poll_status1", 128'(status), 128'(STUB_DATA));
        tick();
        checkOutput("poll_run1", obsA(), vDone());
        repeat (15) tick();
        checkOutput("poll_early2", obsA(), vDone());
        tick();
        checkOutput("poll_rd2", obsA(), vRd());
        tick();
        tick();
        checkOutput("poll_run2", obsA(), vDone());

        $display("[TB] write and poll collide");
        repeat (15) tick();
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        tick();
        checkOutput("coll_upd", obsA(), vUpd(2'd1));
        applyStimulus(1'b0, 1'b0, 2'd1, 1'b0);
        tick();
        checkOutput("coll_gap", obsA(), vBusy());
        tick();
        checkOutput("coll_run", obsA(), vDone());
        tick();
        checkOutput("coll_rd", obsA(), vRd());
        tick();
        checkOutput("coll_cap", obsA(), vCap());
        tick();
        checkOutput("coll_run2", obsA(), vDone());
        repeat (20) tick();
        checkOutput("poll_off", obsA(), vDone());

        $display("[TB] reboot from RUN");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        checkBoot("reboot", 1'b1, 1'b1);
        tick();
        checkOutput("no_ack", obsA(), vDone());

        $display("[TB] reset during RAM write 2");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        start = 1'b0;
        repeat (4) tick();
        checkOutput("mid_ram2", obsA(), expBoot(5));
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
        #2;
        clrn = 1'b0;
        #1;
        checkOutput("async_rst", obsA(), 128'd0);
        checkOutput("async_status", 128'(status), 128'd0);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        checkBoot("boot_req", 1'b0, 1'b0);
        tick();
        checkOutput("held_req_upd", obsA(), vUpd(2'd3));
        applyStimulus(1'b0, 1'b0, 2'd3, 1'b0);
        tick();
        checkOutput("held_req_gap", obsA(), vBusy());

        $display("[TB] manual start");
        checkOutput("man_still_idle", obsM(), 128'd0);
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        checkOutput("man_ram0", obsM(), vec(1'b1, 2'd0, words[0], 1'b0, 1'b0, 2'd0, 32'd0,
                                            1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        checkOutput("man_gap", obsM(), vBusy());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_cfg_loader.md
Name: dec_cfg_loader

Overview:
- Upstream configuration master for the semaphore controller `dec`; drives its ctl_* register port and ram_* divisor-RAM port.
- On boot, writes the four divisor-RAM words and the initial divisor register, then enables the semaphore.
- At runtime, serves divisor-change requests over a req/ack handshake and periodically polls status register 3, presenting the captured value.

Parameters:
- INIT_W0, 32'h0A3C5032, divisor RAM word 0 (bytes 10,60,80,50).
- INIT_W1, 32'h0A1E0A64, divisor RAM word 1 (bytes 10,30,10,100).
- INIT_W2, 32'h0A1E281E, divisor RAM word 2 (bytes 10,30,40,30).
- INIT_W3, 32'h0A463214, divisor RAM word 3 (bytes 10,70,50,20).
- INIT_DIV, 2'd0, divisor index written to reg 1 at boot.
- AUTO_START, 1, 1 = boot begins automatically after reset release; 0 = wait for start.
- POLL_PERIOD, 16, cycles between status reads in RUN (legal range 2..65535).

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  boot request pulse; used when AUTO_START=0, or to reconfigure from RUN.
- div_req  in  1  divisor-change request; level, held until div_ack.
- div_val  in  2  requested divisor index; sampled when div_ack is high.
- div_ack  out  1  one-cycle pulse, coincident with the reg-1 write.
- poll_en  in  1  enables periodic status polling.
- status  out  32  last captured ctl_rddata from reg 3.
- status_vld  out  1  one-cycle pulse when status updates.
- busy  out  1  high in every state except IDLE and RUN.
- done  out  1  high while in RUN.
- ctl_wr  out  1  register write strobe.
- ctl_rd  out  1  register read strobe.
- ctl_addr  out  2  register offset.
- ctl_wrdata  out  32  register write data.
- ctl_rddata  in  32  register read data; valid on the edge after ctl_rd.
- ram_wr  out  1  divisor RAM write strobe.
- ram_addr  out  2  divisor RAM address.
- ram_wrdata  out  32  divisor RAM write data.

Behaviour:
- Reset (async, clrn=0): all outputs 0, including addr/data buses and status; state IDLE; poll timer 0; RAM index 0.
- All outputs are registered. When no strobe is active, the addr/data buses are driven 0, never X.
- Every transaction holds its strobe for exactly 1 cycle and is followed by 1 mandatory idle cycle (GAP). At most one strobe is active in any cycle.
- States: IDLE, RAM_WR, DIV_WR, EN_WR, GAP, RUN, UPD_WR, POLL_RD, POLL_CAP.
- IDLE:
  - AUTO_START=1 → RAM_WR on the first edge after clrn rises.
  - AUTO_START=0 → RAM_WR when start=1.
- RAM_WR: ram_wr=1, ram_addr=idx, ram_wrdata=INIT_W[idx]; then GAP. After GAP, return to RAM_WR with idx+1 until idx=3, then go to DIV_WR.
- DIV_WR: ctl_wr=1, ctl_addr=1, ctl_wrdata={30'b0,INIT_DIV}; GAP; then EN_WR.
- EN_WR: ctl_wr=1, ctl_addr=0, ctl_wrdata=32'd1; GAP; then RUN.
- Boot timing (AUTO_START=1): ram strobes on cycles 1,3,5,7 after release; reg-1 write on cycle 9; enable on cycle 11; done=1 from cycle 13.
- Poll timer:
  - Counts only in RUN with poll_en=1. It is cleared while poll_en=0 and when leaving RUN, and it does not advance outside RUN.
  - At count POLL_PERIOD-1 it sets poll_pend and wraps to 0.
- RUN priority (highest first): start → restart boot at RAM_WR idx 0, done drops; div_req → UPD_WR; poll_pend → POLL_RD.
- UPD_WR: ctl_wr=1, ctl_addr=1, ctl_wrdata={30'b0,div_val}, div_ack=1 in the same cycle; GAP; RUN.
- POLL_RD: ctl_rd=1, ctl_addr=3; clear poll_pend.
- POLL_CAP: status<=ctl_rddata, status_vld=1 for 1 cycle; then RUN.
- Simultaneous div_req and poll_pend: the write goes first. The poll stays pending and issues on the first RUN cycle after the write's GAP.
- div_req asserted during boot: no ack until RUN is reached; the request is then served first.
- start asserted while busy: ignored.
- poll_en dropped while poll_pend is set: the pending read still completes.
- div_req deasserted before ack: no write, no ack.
- Reset mid-transaction: strobes drop immediately (async). No partial state is retained; boot restarts from idx 0 after release (AUTO_START=1).

Test Plan:
- AUTO_START=1, reset release → ram_wr pulses on cycles 1,3,5,7 with addr 0..3 and data 0A3C5032, 0A1E0A64, 0A1E281E, 0A463214; ctl_wr addr1 data 0 on cycle 9; ctl_wr addr0 data 1 on cycle 11; done=1 on cycle 13; busy=1 on cycles 1..12.
- In RUN, div_req=1 with div_val=2 → next cycle ctl_wr=1, addr=1, wrdata=2, div_ack=1; done stays high afterwards; repeat for div_val 0..3 with no lost or duplicated acks.
- poll_en=1, POLL_PERIOD=16, stub returns 32'hA5A5_0003 → ctl_rd addr3 every 18 cycles (period plus read plus capture); status=A5A50003 with status_vld pulsed one cycle after ctl_rd.
- div_req rises in the same cycle poll_pend sets → UPD_WR first, GAP, then POLL_RD; both complete; ctl_wr and ctl_rd never high together.
- div_req held high from reset → div_ack appears only after done=1, as the first RUN transaction.
- clrn pulled low during the RAM_WR of idx 2 → all outputs 0 immediately; after release the full boot sequence repeats from ram_addr 0. With AUTO_START=0, nothing happens until start is pulsed.
